lshift_reg: RTL and testbench

LSHIFT_REG -- requirements
Module: lshift_reg

---
 rtl/lshift_reg_pkg.sv | 16 +
 rtl/lshift_reg.sv | 52 +++++
 tb/tb_lshift_reg.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/lshift_reg_pkg.sv
// Shared constants and the rotate-left helper for lshift_reg.
package lshift_reg_pkg;

  localparam int DEFAULT_WIDTH = 8;
  // Upper bound on WIDTH; the helper works on a wide vector and masks to the real width.
  localparam int ROT_MAX_WIDTH = 1024;
  localparam logic [ROT_MAX_WIDTH-1:0] RESET_VAL = {ROT_MAX_WIDTH{1'b0}};

  function automatic logic [ROT_MAX_WIDTH-1:0] rotl1(input logic [ROT_MAX_WIDTH-1:0] val,
                                                     input int unsigned width);
    logic [ROT_MAX_WIDTH-1:0] mask;
    mask  = {ROT_MAX_WIDTH{1'b1}} >> (ROT_MAX_WIDTH - width);
    rotl1 = ((val << 1) | {{(ROT_MAX_WIDTH-1){1'b0}}, val[width-1]}) & mask;
  endfunction

endpackage

// File: rtl/lshift_reg.sv
// Loadable rotate-left register with synchronous active-low reset.
// Define LSHIFT_REG_ASSERT_EN to compile in simulation-only rotation/X checks.
module lshift_reg
  import lshift_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] load_val,
  input  logic             load_en,
  output logic [WIDTH-1:0] op
);

  logic [WIDTH-1:0] op_q;
  logic [WIDTH-1:0] op_d;

  // Next value: parallel load wins over rotation.
  always_comb begin
    op_d = op_q;
    if (load_en) begin
      op_d = load_val;
    end else begin
      op_d = WIDTH'(rotl1(ROT_MAX_WIDTH'(op_q), WIDTH));
    end
  end

  // State register; reset has top priority and is sampled on the clock.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      op_q <= WIDTH'(RESET_VAL);
    end else begin
      op_q <= op_d;
    end
  end

  assign op = op_q;

`ifdef LSHIFT_REG_ASSERT_EN
  a_popcount: assert property (@(posedge clk) (rstn === 1'b1 && load_en === 1'b0)
      |=> $countones(op_q) == $countones($past(op_q)))
    else $error("lshift_reg: population count changed while rotating");

  a_rotate: assert property (@(posedge clk) (rstn === 1'b1 && load_en === 1'b0)
      |=> op_q == WIDTH'(rotl1(ROT_MAX_WIDTH'($past(op_q)), WIDTH)))
    else $error("lshift_reg: op is not previous value rotated left by one");

  a_known: assert property (@(posedge clk) !$isunknown({rstn, load_en}))
    else $error("lshift_reg: rstn or load_en unknown at clock edge");
`endif

endmodule

// File: tb/tb_lshift_reg.sv
// Scoreboard bench for lshift_reg: directed vectors on 8- and 16-bit instances.
module tb_lshift_reg;

  typedef struct {
    logic [7:0]  exp8;
    logic        chk16;
    logic [15:0] exp16;
    string       name;
  } exp_t;

  logic        clk;
  logic        rstn;
  logic [7:0]  load_val;
  logic        load_en;
  logic [7:0]  op;
  logic [15:0] load_val16;
  logic        load_en16;
  logic [15:0] op16;

  exp_t sb[$];
  int   compared;
  int   mismatched;
  logic        chk16_g;
  logic [15:0] exp16_g;
  bit   stim_done;

  lshift_reg #(.WIDTH(8)) dut8 (
    .clk(clk), .rstn(rstn), .load_val(load_val), .load_en(load_en), .op(op)
  );

  lshift_reg #(.WIDTH(16)) dut16 (
    .clk(clk), .rstn(rstn), .load_val(load_val16), .load_en(load_en16), .op(op16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input logic r, input logic le, input logic [7:0] lv,
                      input logic [7:0] e, input string nm);
    exp_t t;
    rstn     = r;
    load_en  = le;
    load_val = lv;
    t.exp8   = e;
    t.chk16  = chk16_g;
    t.exp16  = exp16_g;
    t.name   = nm;
    sb.push_back(t);
    chk16_g  = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: after every rising edge, compare against the oldest expectation.
  initial begin
    exp_t t;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        t = sb.pop_front();
        compared++;
        if (op !== t.exp8) begin
          mismatched++;
          $display("FAIL %s: op=%h expected %h", t.name, op, t.exp8);
        end
        if (t.chk16) begin
          compared++;
          if (op16 !== t.exp16) begin
            mismatched++;
            $display("FAIL %s16: op=%h expected %h", t.name, op16, t.exp16);
          end
        end
      end
    end
  end

  logic [7:0] walk [20];
  logic [7:0] rot_a5 [8];

  initial begin
    compared   = 0;
    mismatched = 0;
    stim_done  = 1'b0;
    chk16_g    = 1'b0;
    exp16_g    = 16'h0000;
    rstn       = 1'b0;
    load_en    = 1'b0;
    load_val   = 8'h01;
    load_en16  = 1'b0;
    load_val16 = 16'h0000;
    walk = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02, 8'h04,
             8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
    rot_a5 = '{8'h4B, 8'h96, 8'h2D, 8'h5A, 8'hB4, 8'h69, 8'hD2, 8'hA5};
    @(negedge clk);

    // Reset holds zero; rotating zeros stays zero.
    chk16_g = 1'b1; exp16_g = 16'h0000;
    step(1'b0, 1'b0, 8'h01, 8'h00, "rst1");
    step(1'b0, 1'b0, 8'h01, 8'h00, "rst2");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h01, 8'h00, "rot_zero");

    // Walking one with wrap.
    step(1'b1, 1'b1, 8'h01, 8'h01, "load01");
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 8'h00, walk[i], "walk");

    // Pattern rotation with load_val toggling underneath.
    step(1'b1, 1'b1, 8'hA5, 8'hA5, "loadA5");
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'hF0 ^ 8'(i), rot_a5[i], "rotA5");

    step(1'b1, 1'b1, 8'h00, 8'h00, "load00");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h5A, 8'h00, "rot00");
    step(1'b1, 1'b1, 8'hFF, 8'hFF, "loadFF");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00, 8'hFF, "rotFF");

    // Mid-rotation reset: op must not move until the next edge.
    step(1'b1, 1'b1, 8'h81, 8'h81, "load81");
    step(1'b1, 1'b0, 8'h00, 8'h03, "rot81");
    rstn = 1'b0;
    #1;
    compared++;
    if (op !== 8'h03) begin
      mismatched++;
      $display("FAIL sync_rst: op=%h expected %h", op, 8'h03);
    end
    step(1'b0, 1'b0, 8'h00, 8'h00, "rst_mid");
    step(1'b1, 1'b0, 8'h00, 8'h00, "post_rst_rot");
    step(1'b0, 1'b1, 8'h3C, 8'h00, "rst_wins");
    step(1'b1, 1'b1, 8'h55, 8'h55, "load_after_rst");

    // Back-to-back loads; 16-bit wrap runs alongside.
    load_en16 = 1'b1; load_val16 = 16'h8001;
    chk16_g = 1'b1; exp16_g = 16'h8001;
    step(1'b1, 1'b1, 8'h11, 8'h11, "hold_load1");
    load_en16 = 1'b0; load_val16 = 16'hFFFF;
    chk16_g = 1'b1; exp16_g = 16'h0003;
    step(1'b1, 1'b1, 8'h22, 8'h22, "hold_load2");
    chk16_g = 1'b1; exp16_g = 16'h0006;
    step(1'b1, 1'b1, 8'h33, 8'h33, "hold_load3");
    step(1'b1, 1'b0, 8'h44, 8'h66, "ignore_lv1");
    step(1'b1, 1'b0, 8'h99, 8'hCC, "ignore_lv2");

    stim_done = 1'b1;
    @(posedge clk);
    #2;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL drain: pending=%0d expected %0d", sb.size(), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: done=%0d expected %0d", stim_done, 1);
    $fatal(1, "bench timeout");
  end

endmodule
